tcb_dev_gpio: RTL and testbench
===============================

Name: tcb_dev_gpio

Overview:
- Bus-protocol-independent GPIO controller core with a flat register interface: separate write and read ports, 3-bit word address, zero-latency response.
- Drives output data and output enables per pin and samples pin inputs through a configurable synchronizer.
- Supports per-pin edge interrupts, combined into one level IRQ.
- TCB protocol wrappers (e.g. the TCB-Lite device) instantiate it; they gate enables with the transfer strobe and tie response status/ready.

Parameters:
- GPIO_DAT, 32, number of GPIO pins.
- GPIO_CDC, 2, input synchronizer flop stages; 0 bypasses the synchronizer.
- SYS_DAT, 32, system data width; must be >= GPIO_DAT.
- SYS_IEN, 0, implement the input-enable register.
- SYS_IRQ, all ones (GPIO_DAT bits), per-pin interrupt implementation mask.
- SYS_MIN, 0, minimal mode: configuration registers are write-only.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- gpio_o  out  GPIO_DAT  output data.
- gpio_e  out  GPIO_DAT  output enable (1 = drive).
- gpio_i  in  GPIO_DAT  pin input, may be asynchronous.
- sys_wen  in  1  write enable.
- sys_wad  in  3  write word address.
- sys_wdt  in  SYS_DAT  write data.
- sys_ren  in  1  read enable.
- sys_rad  in  3  read word address.
- sys_rdt  out  SYS_DAT  read data.
- irq  out  1  interrupt request, level, active-high.

Behaviour:
- Interface: one clock domain (clk). Reset is asynchronous, active-low. All registers, including synchronizer and edge-history flops, clear to 0 on reset.
- Register map (word address):
  - 0 OUT: rw; value drives gpio_o.
  - 1 ENA: rw; value drives gpio_e.
  - 2 INP: ro; synchronized input.
  - 3 IEN: rw; present only if SYS_IEN, otherwise reads 0 and writes are ignored.
  - 4 RISE: rw; rising-edge interrupt enable.
  - 5 FALL: rw; falling-edge interrupt enable.
  - 6 STS: interrupt status; writing 1 to a bit clears it.
  - 7: reserved; reads 0, writes ignored.
- Bits of RISE, FALL and STS whose SYS_IRQ bit is 0 are constant 0. If SYS_IRQ is all zero, addresses 4–6 behave as reserved.
- Writes take effect at the clk edge where sys_wen=1. Write data bits above GPIO_DAT are ignored.
- Reads are combinational, with zero-cycle latency. sys_rdt is the addressed register, zero-extended to SYS_DAT, when sys_ren=1, and 0 when sys_ren=0. Reads have no side effects.
- SYS_MIN=1: only INP and STS are readable; all other addresses read 0. Writes are unchanged.
- Simultaneous read and write of the same address in one cycle: the read returns the old value.
- Input path:
  - If SYS_IEN, raw input is gpio_i & IEN, so disabled pins read 0. Otherwise raw input is gpio_i.
  - The raw input passes through GPIO_CDC flop stages. INP reflects it GPIO_CDC cycles later, or immediately when GPIO_CDC=0.
- Edge detection:
  - A history register holds the previous INP value.
  - rise = INP & ~prev; fall = ~INP & prev.
  - An STS bit sets when (rise & RISE) | (fall & FALL) is true for that bit, and the bit is implemented.
- STS bits are sticky until cleared. If a set event and a W1C hit the same bit in the same cycle, the set wins.
- irq = |STS, registered state, no extra latency beyond the STS flop.
- Reset mid-operation clears everything immediately; irq and outputs go to 0 asynchronously.

Test Plan:
- Reset: assert rst=0 → gpio_o=0, gpio_e=0, irq=0; all address reads return 0.
- Output/enable registers: write OUT=0xA5A5_5A5A, ENA=0xFFFF_0000 → next cycle gpio_o and gpio_e match; readback of addresses 0 and 1 matches. With SYS_MIN=1, the same reads return 0.
- Input synchronizer: set gpio_i=0x1234_5678 with GPIO_CDC=2 → INP reads 0 for 2 cycles, then 0x1234_5678. With GPIO_CDC=0, INP reflects gpio_i in the same cycle.
- Input enable (SYS_IEN=1): gpio_i=0xFFFF_FFFF, IEN=0x0000_00FF → INP=0x0000_00FF.
- Rising-edge interrupt:
  - RISE=0x1; drive gpio_i[0] 0→1 → STS=0x1 and irq=1 after GPIO_CDC+1 cycles.
  - Write STS=0x1 → irq=0.
  - An edge on bit 1 with RISE[1]=0 leaves STS unchanged.
- Falling-edge interrupt and clear priority: FALL=0x2; write STS=0x2 in the same cycle that a falling edge on bit 1 is detected → STS[1] stays 1. With SYS_IRQ=0x1, FALL reads 0x0 after writing 0x2.

Source files
------------

// File: rtl/tcb_dev_gpio.sv
// rtl/tcb_dev_gpio.sv - GPIO controller core with flat register port
// Output/enable registers, synchronized inputs and per-pin edge interrupts.
module tcb_dev_gpio #(
  parameter int unsigned         GPIO_DAT = 32,
  parameter int unsigned         GPIO_CDC = 2,
  parameter int unsigned         SYS_DAT  = 32,
  parameter bit                  SYS_IEN  = 1'b0,
  parameter logic [GPIO_DAT-1:0] SYS_IRQ  = '1,
  parameter bit                  SYS_MIN  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  output logic [GPIO_DAT-1:0] gpio_o,
  output logic [GPIO_DAT-1:0] gpio_e,
  input  logic [GPIO_DAT-1:0] gpio_i,
  input  logic                sys_wen,
  input  logic [2:0]          sys_wad,
  input  logic [SYS_DAT-1:0]  sys_wdt,
  input  logic                sys_ren,
  input  logic [2:0]          sys_rad,
  output logic [SYS_DAT-1:0]  sys_rdt,
  output logic                irq
);

  localparam logic [GPIO_DAT-1:0] IRQ_MSK = SYS_IRQ;

  logic [GPIO_DAT-1:0] wdt;
  logic [GPIO_DAT-1:0] out_r, ena_r, ien_r, rise_r, fall_r, sts_r, prev_r;
  logic [GPIO_DAT-1:0] raw, inp, sts_set, sts_clr, rd_val;

  assign wdt = sys_wdt[GPIO_DAT-1:0];

  generate
    if (SYS_IEN) begin : g_ien
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          ien_r <= '0;
        end else if (sys_wen && sys_wad == 3'd3) begin
          ien_r <= wdt;
        end
      end
      assign raw = gpio_i & ien_r;
    end else begin : g_no_ien
      assign ien_r = '0;
      assign raw   = gpio_i;
    end
  endgenerate

  generate
    if (GPIO_CDC == 0) begin : g_no_sync
      assign inp = raw;
    end else begin : g_sync
      logic [GPIO_DAT-1:0] sync_r [GPIO_CDC];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < GPIO_CDC; i++) sync_r[i] <= '0;
        end else begin
          sync_r[0] <= raw;
          for (int i = 1; i < GPIO_CDC; i++) sync_r[i] <= sync_r[i-1];
        end
      end
      assign inp = sync_r[GPIO_CDC-1];
    end
  endgenerate

  // A new edge event overrides a simultaneous write-1-to-clear.
  assign sts_set = ((inp & ~prev_r & rise_r) | (~inp & prev_r & fall_r)) & IRQ_MSK;
  assign sts_clr = (sys_wen && sys_wad == 3'd6) ? wdt : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_r  <= '0;
      ena_r  <= '0;
      rise_r <= '0;
      fall_r <= '0;
      sts_r  <= '0;
      prev_r <= '0;
    end else begin
      if (sys_wen) begin
        case (sys_wad)
          3'd0:    out_r  <= wdt;
          3'd1:    ena_r  <= wdt;
          3'd4:    rise_r <= wdt & IRQ_MSK;
          3'd5:    fall_r <= wdt & IRQ_MSK;
          default: ;
        endcase
      end
      sts_r  <= (sts_r & ~sts_clr) | sts_set;
      prev_r <= inp;
    end
  end

  assign gpio_o = out_r;
  assign gpio_e = ena_r;
  assign irq    = |sts_r;

  always_comb begin
    rd_val = '0;
    if (sys_ren) begin
      case (sys_rad)
        3'd0:    rd_val = out_r;
        3'd1:    rd_val = ena_r;
        3'd2:    rd_val = inp;
        3'd3:    rd_val = ien_r;
        3'd4:    rd_val = rise_r;
        3'd5:    rd_val = fall_r;
        3'd6:    rd_val = sts_r;
        default: rd_val = '0;
      endcase
      // Minimal mode hides configuration readback; only INP and STS remain visible.
      if (SYS_MIN && sys_rad != 3'd2 && sys_rad != 3'd6) rd_val = '0;
    end
    sys_rdt = '0;
    sys_rdt[GPIO_DAT-1:0] = rd_val;
  end

endmodule

// File: tb/tb_tcb_dev_gpio.sv
// tb/tb_tcb_dev_gpio.sv - self-checking bench for tcb_dev_gpio
// Three configurations share one stimulus stream and are checked against a queue-based model.
module tb_tcb_dev_gpio;
  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] gpio_i = '0;
  logic        sys_wen = 1'b0;
  logic [2:0]  sys_wad = '0;
  logic [31:0] sys_wdt = '0;
  logic        sys_ren = 1'b0;
  logic [2:0]  sys_rad = '0;
  logic [31:0] g_o [N];
  logic [31:0] g_e [N];
  logic [31:0] rdt [N];
  logic        irq_w [N];

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_out [N], m_ena [N], m_ien [N], m_rise [N], m_fall [N], m_sts [N], m_prev [N];
  logic [31:0] hist [N][$];

  always #10 clk = ~clk;

  tcb_dev_gpio #(.GPIO_DAT(32), .GPIO_CDC(2), .SYS_DAT(32), .SYS_IEN(1'b0),
                 .SYS_IRQ(32'hFFFF_FFFF), .SYS_MIN(1'b0)) u_a (
    .clk(clk), .rst(rst), .gpio_o(g_o[0]), .gpio_e(g_e[0]), .gpio_i(gpio_i),
    .sys_wen(sys_wen), .sys_wad(sys_wad), .sys_wdt(sys_wdt), .sys_ren(sys_ren),
    .sys_rad(sys_rad), .sys_rdt(rdt[0]), .irq(irq_w[0]));

  tcb_dev_gpio #(.GPIO_DAT(32), .GPIO_CDC(0), .SYS_DAT(32), .SYS_IEN(1'b1),
                 .SYS_IRQ(32'h0000_0001), .SYS_MIN(1'b0)) u_b (
    .clk(clk), .rst(rst), .gpio_o(g_o[1]), .gpio_e(g_e[1]), .gpio_i(gpio_i),
    .sys_wen(sys_wen), .sys_wad(sys_wad), .sys_wdt(sys_wdt), .sys_ren(sys_ren),
    .sys_rad(sys_rad), .sys_rdt(rdt[1]), .irq(irq_w[1]));

  tcb_dev_gpio #(.GPIO_DAT(32), .GPIO_CDC(2), .SYS_DAT(32), .SYS_IEN(1'b0),
                 .SYS_IRQ(32'hFFFF_FFFF), .SYS_MIN(1'b1)) u_c (
    .clk(clk), .rst(rst), .gpio_o(g_o[2]), .gpio_e(g_e[2]), .gpio_i(gpio_i),
    .sys_wen(sys_wen), .sys_wad(sys_wad), .sys_wdt(sys_wdt), .sys_ren(sys_ren),
    .sys_rad(sys_rad), .sys_rdt(rdt[2]), .irq(irq_w[2]));

  function automatic int cfg_cdc(int d);
    return (d == 1) ? 0 : 2;
  endfunction

  function automatic bit cfg_ien(int d);
    return d == 1;
  endfunction

  function automatic logic [31:0] cfg_irq(int d);
    return (d == 1) ? 32'h0000_0001 : 32'hFFFF_FFFF;
  endfunction

  function automatic bit cfg_min(int d);
    return d == 2;
  endfunction

  function automatic logic [31:0] m_raw(int d);
    return cfg_ien(d) ? (gpio_i & m_ien[d]) : gpio_i;
  endfunction

  // INP is the raw input as it was cfg_cdc edges ago (or right now when there is no synchronizer).
  function automatic logic [31:0] m_inp(int d);
    if (cfg_cdc(d) == 0) return m_raw(d);
    return hist[d][cfg_cdc(d)-1];
  endfunction

  function automatic logic [31:0] exp_rd(int d, logic ren, logic [2:0] addr);
    logic [31:0] v;
    if (!ren) return 32'h0;
    case (addr)
      3'd0: v = m_out[d];
      3'd1: v = m_ena[d];
      3'd2: v = m_inp(d);
      3'd3: v = cfg_ien(d) ? m_ien[d] : 32'h0;
      3'd4: v = m_rise[d];
      3'd5: v = m_fall[d];
      3'd6: v = m_sts[d];
      default: v = 32'h0;
    endcase
    if (cfg_min(d) && addr != 3'd2 && addr != 3'd6) v = 32'h0;
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < N; d++) begin
      m_out[d] = '0; m_ena[d] = '0; m_ien[d] = '0; m_rise[d] = '0;
      m_fall[d] = '0; m_sts[d] = '0; m_prev[d] = '0;
      hist[d].delete();
      for (int k = 0; k < cfg_cdc(d); k++) hist[d].push_front(32'h0);
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs();
    for (int d = 0; d < N; d++) begin
      chk($sformatf("gpio_o[%0d]", d), g_o[d], m_out[d]);
      chk($sformatf("gpio_e[%0d]", d), g_e[d], m_ena[d]);
      chk($sformatf("irq[%0d]", d), {31'h0, irq_w[d]}, {31'h0, |m_sts[d]});
    end
  endtask

  task automatic chk_rd(logic [2:0] addr, logic ren);
    sys_ren = ren;
    sys_rad = addr;
    #1;
    for (int d = 0; d < N; d++)
      chk($sformatf("rd[%0d] a=%0d ren=%0d", d, addr, ren), rdt[d], exp_rd(d, ren, addr));
  endtask

  task automatic chk_all();
    for (int a = 0; a < 8; a++) chk_rd(3'(a), 1'b1);
  endtask

  // Advance one clock: next model state is computed from pre-edge inputs, committed at the edge.
  task automatic tick();
    logic [31:0] inp [N];
    logic [31:0] raw [N];
    logic [31:0] n_sts [N];
    logic [31:0] set, clr;
    for (int d = 0; d < N; d++) begin
      inp[d] = m_inp(d);
      raw[d] = m_raw(d);
      set = ((inp[d] & ~m_prev[d] & m_rise[d]) | (~inp[d] & m_prev[d] & m_fall[d])) & cfg_irq(d);
      clr = (sys_wen && sys_wad == 3'd6) ? sys_wdt : 32'h0;
      n_sts[d] = (m_sts[d] & ~clr) | set;
    end
    @(posedge clk);
    for (int d = 0; d < N; d++) begin
      m_prev[d] = inp[d];
      m_sts[d]  = n_sts[d];
      if (sys_wen) begin
        case (sys_wad)
          3'd0: m_out[d] = sys_wdt;
          3'd1: m_ena[d] = sys_wdt;
          3'd3: if (cfg_ien(d)) m_ien[d] = sys_wdt;
          3'd4: m_rise[d] = sys_wdt & cfg_irq(d);
          3'd5: m_fall[d] = sys_wdt & cfg_irq(d);
          default: ;
        endcase
      end
      if (cfg_cdc(d) > 0) begin
        hist[d].push_front(raw[d]);
        void'(hist[d].pop_back());
      end
    end
    #1;
  endtask

  task automatic write(logic [2:0] addr, logic [31:0] data);
    sys_wen = 1'b1;
    sys_wad = addr;
    sys_wdt = data;
    chk_rd(addr, 1'b1);
    tick();
    sys_wen = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    chk_outs();
    chk_all();
    rst = 1'b1;

    write(3'd0, 32'hA5A5_5A5A);
    write(3'd1, 32'hFFFF_0000);
    chk_outs();
    chk_all();

    write(3'd3, 32'h0000_00FF);
    gpio_i = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      chk_rd(3'd2, 1'b1);
      tick();
    end
    chk_rd(3'd2, 1'b1);
    gpio_i = 32'hFFFF_FFFF;
    repeat (3) tick();
    chk_rd(3'd2, 1'b1);

    gpio_i = 32'h0;
    repeat (4) tick();
    write(3'd4, 32'h1);
    gpio_i = 32'h1;
    for (int k = 0; k < 4; k++) begin
      chk_outs();
      chk_rd(3'd6, 1'b1);
      tick();
    end
    write(3'd6, 32'h1);
    chk_outs();
    gpio_i = 32'h3;
    repeat (4) tick();
    chk_rd(3'd6, 1'b1);
    chk_outs();

    write(3'd5, 32'h2);
    chk_rd(3'd5, 1'b1);
    gpio_i = 32'h1;
    tick();
    tick();
    write(3'd6, 32'h2);
    chk_rd(3'd6, 1'b1);
    chk_outs();

    repeat (300) begin
      gpio_i  = ($urandom_range(0, 3) == 0) ? $urandom : (gpio_i ^ ($urandom & $urandom & $urandom));
      sys_wen = $urandom_range(0, 2) == 0;
      sys_wad = 3'($urandom);
      sys_wdt = $urandom;
      chk_rd(3'($urandom), $urandom_range(0, 4) != 0);
      tick();
      sys_wen = 1'b0;
      chk_outs();
    end

    #3;
    rst = 1'b0;
    #1;
    model_reset();
    chk_outs();
    chk_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
